// File: rtl/mem_access_if.sv
// Data-memory bus between mem_access (master) and the data memory (slave).
// Signal names keep the master's point of view: *_o driven by mem_access, *_i by memory.
interface mem_access_if;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [31:0] dmem_addr_o;
   logic [3:0]  dmem_be_o;
   logic [31:0] dmem_wdata_o;
   logic [31:0] dmem_rdata_i;
   logic        dmem_ack_i;

   modport master (
      output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      input  dmem_rdata_i, dmem_ack_i
   );

   modport slave (
      input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o,
      output dmem_rdata_i, dmem_ack_i
   );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: IDLE/REQ/DONE sequencer driving a word-addressed data-memory bus.
// Define MEM_MISALIGN_TRAP_EN to flag misaligned half/word accesses as errors instead of issuing them.
module mem_access #(
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start_i,
   input  logic [31:0]  ir_i,
   input  logic [31:0]  addr_i,
   input  logic [31:0]  rs2_i,
   mem_access_if.master dmem,
   output logic [31:0]  mem_o,
   output logic         wd_q_readin_o,
   output logic         busy_o,
   output logic         err_o
);
   typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

   state_e      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] daddr_q, daddr_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] mem_q, mem_d;
   logic        done_q, done_d;
   logic        err_q, err_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_load, is_store, f3_legal, misaligned;
   logic [3:0]  lane_be;
   logic [31:0] lane_wdata;
   logic [15:0] lane_rd;
   logic [31:0] load_ext;
   logic        unused_ir;

   assign opcode    = ir_i[6:0];
   assign funct3    = ir_i[14:12];
   assign unused_ir = ^{ir_i[31:15], ir_i[11:7]};
   assign is_load   = (opcode == OP_LOAD);
   assign is_store  = (opcode == OP_STORE);
   assign f3_legal  = is_load ? (funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})
                              : (funct3 inside {3'b000, 3'b001, 3'b010});

`ifdef MEM_MISALIGN_TRAP_EN
   assign misaligned = ((funct3[1:0] == 2'b01) && addr_i[0]) ||
                       ((funct3[1:0] == 2'b10) && (addr_i[1:0] != 2'b00));
`else
   assign misaligned = 1'b0;
`endif

   // Byte lanes and replicated store data for the incoming access size.
   always_comb begin
      // NOTE: every signal assigned in a combinational block gets a default first, so no latch is inferred.
      lane_be    = 4'b1111;
      lane_wdata = rs2_i;
      case (funct3[1:0])
         2'b00: begin
            lane_be    = 4'b0001 << addr_i[1:0];
            lane_wdata = {4{rs2_i[7:0]}};
         end
         2'b01: begin
            lane_be    = 4'b0011 << addr_i[1:0];
            lane_wdata = {2{rs2_i[15:0]}};
         end
         default: ;
      endcase
   end

   assign lane_rd = 16'(dmem.dmem_rdata_i >> {off_q, 3'b000});

   always_comb begin
      load_ext = dmem.dmem_rdata_i;
      case (f3_q)
         3'b000:  load_ext = {{24{lane_rd[7]}}, lane_rd[7:0]};
         3'b001:  load_ext = {{16{lane_rd[15]}}, lane_rd};
         3'b100:  load_ext = {24'h0, lane_rd[7:0]};
         3'b101:  load_ext = {16'h0, lane_rd};
         default: ;
      endcase
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      f3_d    = f3_q;
      off_d   = off_q;
      req_d   = req_q;
      we_d    = we_q;
      daddr_d = daddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      mem_d   = mem_q;
      done_d  = 1'b0;
      err_d   = err_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = DONE;
               done_d  = 1'b1;
               if (is_load || is_store) begin
                  if (!f3_legal || misaligned) begin
                     err_d = 1'b1;
                  end else begin
                     state_d = REQ;
                     done_d  = 1'b0;
                     cnt_d   = 8'd0;
                     f3_d    = funct3;
                     off_d   = addr_i[1:0];
                     req_d   = 1'b1;
                     we_d    = is_store;
                     daddr_d = {addr_i[31:2], 2'b00};
                     be_d    = lane_be;
                     wdata_d = is_store ? lane_wdata : 32'h0;
                  end
               end
            end
         end
         REQ: begin
            // An ack in the expiry cycle is checked first, so it beats the timeout.
            if (dmem.dmem_ack_i || (cnt_q == CNT_LAST)) begin
               state_d = DONE;
               done_d  = 1'b1;
               req_d   = 1'b0;
               we_d    = 1'b0;
               daddr_d = 32'h0;
               be_d    = 4'h0;
               wdata_d = 32'h0;
               if (!dmem.dmem_ack_i) begin
                  mem_d = 32'h0;
                  err_d = 1'b1;
               end else if (!we_q) begin
                  mem_d = load_ext;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= 8'd0;
         f3_q    <= 3'b0;
         off_q   <= 2'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         daddr_q <= 32'h0;
         be_q    <= 4'h0;
         wdata_q <= 32'h0;
         mem_q   <= 32'h0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         cnt_q   <= cnt_d;
         f3_q    <= f3_d;
         off_q   <= off_d;
         req_q   <= req_d;
         we_q    <= we_d;
         daddr_q <= daddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         mem_q   <= mem_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign dmem.dmem_req_o   = req_q;
   assign dmem.dmem_we_o    = we_q;
   assign dmem.dmem_addr_o  = daddr_q;
   assign dmem.dmem_be_o    = be_q;
   assign dmem.dmem_wdata_o = wdata_q;
   assign mem_o             = mem_q;
   assign wd_q_readin_o     = done_q;
   assign busy_o            = (state_q != IDLE);
   assign err_o             = err_q;
endmodule

// File: tb/tb_mem_access.sv
// Randomized bench for mem_access against a transaction-level model of loads, stores,
// errors, timeouts and reset abandonment.
module tb_mem_access;
   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        start_i;
   logic [31:0] ir_i, addr_i, rs2_i;
   logic [31:0] mem_o;
   logic        wd_q_readin_o, busy_o, err_o;

   mem_access_if bus();

   mem_access #(.TIMEOUT_CYCLES(TO)) dut (
      .clk           (clk),
      .reset         (reset),
      .start_i       (start_i),
      .ir_i          (ir_i),
      .addr_i        (addr_i),
      .rs2_i         (rs2_i),
      .dmem          (bus),
      .mem_o         (mem_o),
      .wd_q_readin_o (wd_q_readin_o),
      .busy_o        (busy_o),
      .err_o         (err_o)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   logic [31:0] exp_mem  = 32'h0;
   logic        exp_err  = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
   endtask

   function automatic logic [31:0] mk_ir(input logic [6:0] op, input logic [2:0] f3);
      logic [31:0] r;
      r = $urandom;
      return {r[31:15], f3, r[11:7], op};
   endfunction

   function automatic logic [31:0] load_model(input logic [2:0] f3, input int off,
                                              input logic [31:0] rdata);
      logic [31:0] lane, b, h;
      lane = rdata >> (8 * off);
      b    = lane & 32'hFF;
      h    = lane & 32'hFFFF;
      case (f3)
         3'd0:    return (b < 128) ? b : b + 32'hFFFF_FF00;
         3'd1:    return (h < 32768) ? h : h + 32'hFFFF_0000;
         3'd4:    return b;
         3'd5:    return h;
         default: return rdata;
      endcase
   endfunction

   // One complete transaction; k = REQ cycle in which the memory acks (k > TO: never).
   task automatic run_op(input logic [31:0] ir, input logic [31:0] addr, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int k, input bit skip_data);
      logic [6:0]  op;
      logic [2:0]  f3;
      bit          is_load, is_store, legal, mis;
      int          nbytes, off, n_req;
      logic [31:0] e_addr, e_be, e_wdata;
      op       = ir[6:0];
      f3       = ir[14:12];
      is_load  = (op == 7'b0000011);
      is_store = (op == 7'b0100011);
      legal    = is_load ? (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5)
                         : (is_store && f3 <= 2);
      nbytes   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      off      = int'(addr[1:0]);
      mis      = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis      = (off % nbytes) != 0;
`endif
      e_addr   = addr & 32'hFFFF_FFFC;
      e_be     = (nbytes == 4) ? 32'hF : ((((1 << nbytes) - 1) << off) & 15);
      e_wdata  = (nbytes == 1) ? (rs2 & 32'hFF) * 32'h0101_0101 :
                 (nbytes == 2) ? (rs2 & 32'hFFFF) * 32'h0001_0001 : rs2;

      @(negedge clk);
      start_i = 1'b1; ir_i = ir; addr_i = addr; rs2_i = rs2;
      bus.dmem_ack_i   = 1'($urandom_range(0, 1));
      bus.dmem_rdata_i = $urandom;
      @(negedge clk);
      start_i = 1'b0; ir_i = $urandom; addr_i = $urandom; rs2_i = $urandom;
      bus.dmem_ack_i = 1'b0;

      if (!(legal && !mis)) begin
         if (is_load || is_store) exp_err = 1'b1;
         check("noreq_req", bus.dmem_req_o, 0);
         check("noreq_done", wd_q_readin_o, 1);
         check("noreq_busy", busy_o, 1);
         check("noreq_err", err_o, exp_err);
         if (!skip_data) check("noreq_mem", mem_o, exp_mem);
         @(negedge clk);
         check("noreq_done_end", wd_q_readin_o, 0);
         check("noreq_idle", busy_o, 0);
         return;
      end

      n_req = (k <= TO) ? k : TO;
      for (int c = 1; c <= n_req; c++) begin
         check("req_high", bus.dmem_req_o, 1);
         check("req_busy", busy_o, 1);
         check("req_no_done", wd_q_readin_o, 0);
         check("req_addr", bus.dmem_addr_o, e_addr);
         check("req_we", bus.dmem_we_o, is_store);
         if (is_store && !skip_data) begin
            check("req_be", bus.dmem_be_o, e_be);
            check("req_wdata", bus.dmem_wdata_o, e_wdata);
         end
         bus.dmem_ack_i   = (c == k);
         bus.dmem_rdata_i = (c == k) ? rdata : $urandom;
         start_i = 1'($urandom_range(0, 1));
         ir_i    = $urandom;
         @(negedge clk);
      end

      if (k > TO) begin
         exp_mem = 32'h0;
         exp_err = 1'b1;
      end else if (is_load && !skip_data) begin
         exp_mem = load_model(f3, off, rdata);
      end
      check("done_pulse", wd_q_readin_o, 1);
      check("done_req_low", bus.dmem_req_o, 0);
      check("done_busy", busy_o, 1);
      check("done_err", err_o, exp_err);
      if (!skip_data) check("done_mem", mem_o, exp_mem);
      start_i = 1'($urandom_range(0, 1));
      bus.dmem_ack_i = 1'($urandom_range(0, 1));
      @(negedge clk);
      start_i = 1'b0;
      bus.dmem_ack_i = 1'b0;
      check("idle_done_low", wd_q_readin_o, 0);
      check("idle_busy", busy_o, 0);
      check("idle_req", bus.dmem_req_o, 0);
   endtask

   initial begin
      logic [2:0]  f3;
      logic [6:0]  op;
      logic [31:0] addr;
      int          kind;

      reset = 1'b0; start_i = 1'b0; ir_i = '0; addr_i = '0; rs2_i = '0;
      bus.dmem_ack_i = 1'b0; bus.dmem_rdata_i = '0;
      repeat (2) @(negedge clk);
      check("rst_req", bus.dmem_req_o, 0);
      check("rst_addr", bus.dmem_addr_o, 0);
      check("rst_be", bus.dmem_be_o, 0);
      check("rst_mem", mem_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      reset = 1'b1;

      // Directed cases: LB sign extension, SH lanes, ADD pass-through, LW at 0x006, timeout.
      run_op(mk_ir(7'b0000011, 3'b000), 32'h0000_0103, 32'h0, 32'h80FF_FF7F, 2, 1'b0);
      run_op(mk_ir(7'b0100011, 3'b001), 32'h0000_0202, 32'h0000_ABCD, 32'h0, 1, 1'b0);
      run_op(mk_ir(7'b0110011, 3'b000), 32'h0000_0040, 32'h1234_5678, 32'h0, 1, 1'b0);
      run_op(mk_ir(7'b0000011, 3'b010), 32'h0000_0006, 32'h0, 32'hCAFE_F00D, 1, 1'b0);
      run_op(mk_ir(7'b0000011, 3'b010), 32'h0000_0010, 32'h0, 32'h1111_2222, TO, 1'b0);
      run_op(mk_ir(7'b0000011, 3'b010), 32'h0000_0020, 32'h0, 32'h3333_4444, TO + 5, 1'b0);

      for (int i = 0; i < 80; i++) begin
         kind = int'($urandom_range(0, 9));
         addr = $urandom;
         if (kind < 4) begin
            op = 7'b0000011;
            case ($urandom_range(0, 4))
               0: f3 = 3'd0; 1: f3 = 3'd1; 2: f3 = 3'd2; 3: f3 = 3'd4; default: f3 = 3'd5;
            endcase
         end else if (kind < 8) begin
            op = 7'b0100011;
            f3 = 3'($urandom_range(0, 2));
         end else if (kind == 8) begin
            op = (($urandom_range(0, 1)) != 0) ? 7'b0000011 : 7'b0100011;
            f3 = (op == 7'b0000011) ? 3'(6 + $urandom_range(0, 1)) : 3'($urandom_range(3, 7));
         end else begin
            op = 7'($urandom_range(0, 127));
            if (op == 7'b0000011 || op == 7'b0100011) op = 7'b0010011;
            f3 = 3'($urandom_range(0, 7));
         end
         if (f3[1:0] == 2'b01 && addr[1:0] == 2'b11) addr[1:0] = 2'($urandom_range(0, 2));
         run_op(mk_ir(op, f3), addr, $urandom, $urandom, int'($urandom_range(1, TO + 2)), 1'b0);
      end

      // Halfword at offset 3 has undefined data; only the handshake must complete.
      run_op(mk_ir(7'b0000011, 3'b001), 32'h0000_0303, 32'h0, 32'h5566_7788, 1, 1'b1);

      // Reset in the second REQ cycle abandons the access.
      @(negedge clk);
      start_i = 1'b1; ir_i = mk_ir(7'b0000011, 3'b010); addr_i = 32'h0000_0400;
      @(negedge clk);
      start_i = 1'b0;
      check("rreq_c1", bus.dmem_req_o, 1);
      @(negedge clk);
      check("rreq_c2", bus.dmem_req_o, 1);
      #2 reset = 1'b0;
      #1;
      check("rreq_req_drop", bus.dmem_req_o, 0);
      check("rreq_we", bus.dmem_we_o, 0);
      check("rreq_addr", bus.dmem_addr_o, 0);
      check("rreq_be", bus.dmem_be_o, 0);
      check("rreq_wdata", bus.dmem_wdata_o, 0);
      check("rreq_mem", mem_o, 0);
      check("rreq_done", wd_q_readin_o, 0);
      check("rreq_busy", busy_o, 0);
      check("rreq_err", err_o, 0);
      exp_mem = 32'h0;
      exp_err = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         check("post_rst_no_done", wd_q_readin_o, 0);
         check("post_rst_idle", busy_o, 0);
      end

      run_op(mk_ir(7'b0110011, 3'b000), 32'h0, 32'h0, 32'h0, 1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
